spike_aer_encoder: RTL
======================

Name: spike_aer_encoder

Overview:
- Downstream of neuron_core. Captures the 4-bit post-neuron spike vector (NEUR_EVENT_OUT) that neuron_core produces on each post-neuron SRAM write.
- Buffers the vectors in a small FIFO and serialises each set bit into a 10-bit AER address.
- Emits the addresses on a 4-phase REQ/ACK output link toward the off-core event interface.

Parameters:
- DEPTH, 8, FIFO entries; power of two, min 2.
- ROW_W, 8, post-neuron row address width. Neuron address = {row, lane}; AER address width = ROW_W+2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SPK_VALID  in  1  capture strobe; driven by CTRL_POST_NEUR_CS && CTRL_POST_NEUR_WE.
- SPK_MASK  in  4  neuron_core NEUR_EVENT_OUT; bit i = neuron {row,i} fired.
- SPK_ROW  in  ROW_W  CTRL_POST_NEURON_ADDRESS[ROW_W+1:2].
- AER_REQ  out  1  request, registered.
- AER_ADDR  out  ROW_W+2  spiking neuron address, registered; stable while AER_REQ=1.
- AER_ACK  in  1  acknowledge from receiver.
- FIFO_FULL  out  1  FIFO count == DEPTH.
- FIFO_EMPTY  out  1  FIFO count == 0.
- DROP_CNT  out  DROP_W  count of rejected non-zero vectors; saturates.
- ENC_IDLE  out  1  FSM in IDLE and FIFO empty.

Behaviour:
- Reset (RST=1 at an edge):
  - FIFO flushed; pointers and count = 0.
  - FSM -> IDLE; work mask = 0.
  - AER_REQ=0, AER_ADDR=0, DROP_CNT=0, FIFO_FULL=0, FIFO_EMPTY=1, ENC_IDLE=1.
  - Reset mid-handshake drops AER_REQ at that edge with no completion; the in-flight event is lost.
- Capture:
  - At an edge with SPK_VALID=1 and SPK_MASK!=0, push {SPK_MASK, SPK_ROW}.
  - SPK_MASK==0 is never pushed and never counted as a drop.
- Full:
  - A push is accepted if count<DEPTH, or if a pop occurs at the same edge.
  - Otherwise the vector is discarded and DROP_CNT increments, holding at 2^DROP_W-1.
  - Simultaneous push+pop leaves count unchanged.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by count (width clog2(DEPTH)+1), not by pointer compare.
- Drain FSM has three states: IDLE, REQ, ACKLO.
  - IDLE: if !FIFO_EMPTY and AER_ACK==0, then:
    - pop head into work regs {wmask, wrow};
    - set AER_ADDR = {wrow, lowest set bit index of wmask};
    - set AER_REQ=1; go to REQ.
    - If AER_ACK==1, wait in IDLE; never raise REQ while ACK is high.
  - REQ: hold AER_REQ and AER_ADDR. When AER_ACK==1:
    - AER_REQ <= 0;
    - clear the serviced bit in wmask;
    - go to ACKLO.
  - ACKLO: when AER_ACK==0, take the first matching branch:
    - wmask!=0: AER_ADDR = next lowest set bit, AER_REQ=1, go to REQ;
    - else if !FIFO_EMPTY: pop and load as in IDLE, AER_REQ=1, go to REQ;
    - else go to IDLE.
- Lane order within a vector is ascending (bit0 first). Vectors are served in FIFO order.
- Latency: with the FSM idle, ACK=0 and an empty FIFO:
  - SPK_VALID sampled at edge k -> entry visible after k;
  - pop and AER_REQ=1 after edge k+1, i.e. REQ visible in cycle k+2.
- Per-event cost: minimum 2 cycles (REQ, ACKLO) with an immediate-responding receiver.
- AER_ADDR changes only on edges where AER_REQ rises. AER_ADDR holds its last value after AER_REQ falls.

Test Plan:
- Single spike: SPK_VALID=1, MASK=4'b0100, ROW=8'h05; ACK mirrors REQ after 1 cycle -> one handshake, AER_ADDR=10'h016, REQ rises cycle k+2, ENC_IDLE=1 afterwards, DROP_CNT=0.
- Multi-bit vector: MASK=4'b1011, ROW=8'h3F -> addresses 0x0FC, 0x0FD, 0x0FF in order, exactly 3 REQ pulses, no address change while REQ=1.
- Overflow: ACK held 0, 10 consecutive SPK_VALID with MASK=4'b0001, rows 0..9 (first REQ stalls) -> 1 popped, 8 buffered, FIFO_FULL=1, DROP_CNT=1. Then release ACK -> rows 0..8 emitted in order; row 9 never appears.
- Zero mask and saturation: 5 pushes of MASK=0 -> FIFO_EMPTY stays 1, DROP_CNT=0. With DROP_W=2 and FIFO full, 6 rejected vectors -> DROP_CNT=3.
- Reset mid-handshake: assert RST while AER_REQ=1 with 3 entries queued -> next cycle AER_REQ=0, FIFO_EMPTY=1, DROP_CNT=0. With ACK still high after release and a new push, REQ stays 0 until ACK=0, then the new event is emitted.
- Push+pop at full: FIFO full, FSM in ACKLO with wmask=0. ACK falls on the same edge as SPK_VALID=1 with MASK=4'b0010 -> push accepted, count stays DEPTH, DROP_CNT unchanged.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//   Captures 4-bit post-neuron spike vectors from neuron_core, buffers them in
//   a small FIFO and serialises every set bit into a ROW_W+2 bit AER address.
//   Each address goes out on a 4-phase REQ/ACK link.
//
// Ports
//   CLK, RST     clock (rising edge), synchronous active-high reset
//   SPK_VALID    capture strobe for SPK_MASK / SPK_ROW
//   SPK_MASK     spike vector, bit i = neuron {row, i} fired
//   SPK_ROW      post-neuron row address
//   AER_REQ      registered request toward the event interface
//   AER_ADDR     registered address {row, lane}, stable while AER_REQ=1
//   AER_ACK      acknowledge from the receiver
//   FIFO_FULL    FIFO holds DEPTH entries
//   FIFO_EMPTY   FIFO holds no entries
//   DROP_CNT     saturating count of non-zero vectors rejected on full
//   ENC_IDLE     drain FSM idle and FIFO empty
module spike_aer_encoder #(
  parameter int DEPTH  = 8,
  parameter int ROW_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPK_VALID,
  input  logic [3:0]        SPK_MASK,
  input  logic [ROW_W-1:0]  SPK_ROW,
  output logic              AER_REQ,
  output logic [ROW_W+1:0]  AER_ADDR,
  input  logic              AER_ACK,
  output logic              FIFO_FULL,
  output logic              FIFO_EMPTY,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic              ENC_IDLE
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ROW_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKLO = 2'd2
  } state_t;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state;
  logic [3:0]       wmask;
  logic [ROW_W-1:0] wrow;

  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic [3:0]       head_mask;
  logic [ROW_W-1:0] head_row;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign FIFO_FULL  = (count == CNT_W'(DEPTH));
  assign FIFO_EMPTY = (count == '0);
  assign ENC_IDLE   = (state == S_IDLE) && FIFO_EMPTY;

  assign head_mask = mem[rd_ptr][ENT_W-1:ROW_W];
  assign head_row  = mem[rd_ptr][ROW_W-1:0];

  // A new vector is fetched from IDLE, or from ACKLO once the current vector
  // is exhausted; either way only while the receiver has released ACK.
  assign pop = !FIFO_EMPTY && !AER_ACK &&
               ((state == S_IDLE) || ((state == S_ACKLO) && (wmask == 4'd0)));

  // A simultaneous pop frees a slot, so a push at full still fits.
  assign push_req = SPK_VALID && (SPK_MASK != 4'd0);
  assign push     = push_req && (!FIFO_FULL || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {SPK_MASK, SPK_ROW};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      DROP_CNT <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop && (DROP_CNT != '1)) DROP_CNT <= DROP_CNT + DROP_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      wmask    <= 4'd0;
      wrow     <= '0;
      AER_REQ  <= 1'b0;
      AER_ADDR <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            wmask    <= head_mask;
            wrow     <= head_row;
            AER_ADDR <= {head_row, low_idx(head_mask)};
            AER_REQ  <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (AER_ACK) begin
            AER_REQ <= 1'b0;
            // The serviced lane is always the lowest set bit.
            wmask   <= wmask & (wmask - 4'd1);
            state   <= S_ACKLO;
          end
        end
        S_ACKLO: begin
          if (!AER_ACK) begin
            if (wmask != 4'd0) begin
              AER_ADDR <= {wrow, low_idx(wmask)};
              AER_REQ  <= 1'b1;
              state    <= S_REQ;
            end else if (pop) begin
              wmask    <= head_mask;
              wrow     <= head_row;
              AER_ADDR <= {head_row, low_idx(head_mask)};
              AER_REQ  <= 1'b1;
              state    <= S_REQ;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
